// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the seven-segment scan controller:
//   state_t   - scan sequencer states (IDLE, SHOW, GAP)
//   SEG_*     - bit positions of each segment inside the 7-bit bus {a..g}
//   SEG_LUT   - hex nibble to active-high segment pattern table
// ---------------------------------------------------------------------------
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // seg[6] is segment a, seg[0] is segment g
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/seven_seg_lut.sv
// ---------------------------------------------------------------------------
// seven_seg_lut
// Purely combinational hex-to-segment decoder.
// Ports:
//   nibble  in  4  hex digit value 0..F
//   seg     out 7  active-high segments {a,b,c,d,e,f,g}
// ---------------------------------------------------------------------------
module seven_seg_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [6:0] pattern;

    assign pattern = SEG_LUT[nibble];

    // Re-pack by named segment position so the table and bus order stay tied
    // to the package definitions.
    assign seg[SEG_A] = pattern[SEG_A];
    assign seg[SEG_B] = pattern[SEG_B];
    assign seg[SEG_C] = pattern[SEG_C];
    assign seg[SEG_D] = pattern[SEG_D];
    assign seg[SEG_E] = pattern[SEG_E];
    assign seg[SEG_F] = pattern[SEG_F];
    assign seg[SEG_G] = pattern[SEG_G];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
// Time-multiplexed scan controller for an N-digit common-segment display.
// Host writes land in a staging buffer; the whole buffer is copied into the
// displayed (committed) buffer at the start of every frame, so a frame never
// shows a mix of old and new digits.
//
// Ports:
//   clk         in   1                 system clock (rising edge)
//   rst         in   1                 synchronous active-high reset
//   en          in   1                 scan enable; low returns to IDLE (dark)
//   wr_valid    in   1                 host write strobe
//   wr_ready    out  1                 write accepted (high whenever not in reset)
//   wr_idx      in   $clog2(NUM_DIGITS) target digit; out-of-range writes dropped
//   wr_data     in   4                 hex nibble
//   digit_sel   out  NUM_DIGITS        one-hot active-high digit enable
//   seg         out  7                 active-high segments, seg[6]=a
//   frame_tick  out  1                 pulse in the first lit cycle of digit 0
//
// Optional build macro:
//   SEVEN_SEG_LZ_BLANK_EN  - blank leading zero digits (digit 0 never blanked)
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
    input  logic [3:0]                    wr_data,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic [6:0]                    seg,
    output logic                          frame_tick
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               commit_next;

    logic [3:0]         staged_reg    [NUM_DIGITS];
    logic [3:0]         staged_next   [NUM_DIGITS];
    logic [3:0]         committed_reg [NUM_DIGITS];

    logic [3:0]         sel_nibble;
    logic [6:0]         lut_seg;
    logic               blank;

    assign wr_ready = ~rst;

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        cnt_next    = cnt_reg;
        commit_next = 1'b0;
        if (!en) begin
            state_next = IDLE;
            idx_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next  = SHOW;
                    idx_next    = '0;
                    cnt_next    = '0;
                    commit_next = 1'b1;
                end
                SHOW: begin
                    if (cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
                        state_next = GAP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
                        state_next = SHOW;
                        cnt_next   = '0;
                        if (idx_reg == IDX_W'(NUM_DIGITS - 1)) begin
                            idx_next    = '0;
                            commit_next = 1'b1;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // ---------------- double-buffered digit storage ----------------
    // The commit copies staged_next rather than staged_reg, so a write accepted
    // in the cycle just before a frame starts is still part of that frame;
    // a write in the commit cycle itself lands after the copy.
    // Out-of-range wr_idx values match no digit and are dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign staged_next[gi] = (wr_valid && wr_ready && (wr_idx == IDX_W'(gi)))
                                     ? wr_data : staged_reg[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    staged_reg[gi]    <= 4'd0;
                    committed_reg[gi] <= 4'd0;
                end else begin
                    staged_reg[gi] <= staged_next[gi];
                    if (commit_next) begin
                        committed_reg[gi] <= staged_next[gi];
                    end
                end
            end
        end
    endgenerate

    // ---------------- output decode (registered state only) ----------------
    assign sel_nibble = committed_reg[idx_reg];

    seven_seg_lut u_lut (
        .nibble (sel_nibble),
        .seg    (lut_seg)
    );

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // Blank the lit digit when it and every higher digit hold zero.
    always_comb begin
        blank = (idx_reg != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(idx_reg)) && (committed_reg[i] != 4'd0)) begin
                blank = 1'b0;
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    assign digit_sel  = (state_reg == SHOW) ? (NUM_DIGITS'(1) << idx_reg) : '0;
    assign seg        = ((state_reg == SHOW) && !blank) ? lut_seg : 7'd0;
    assign frame_tick = (state_reg == SHOW) && (idx_reg == '0) && (cnt_reg == '0);

endmodule
